// File: rtl/shared_op_arbiter_if.sv
// Signal bundle between shared_op_arbiter, its requesters and the shared basic-op unit.
// The arbiter uses the slave modport; the environment (requesters + unit) uses master.
interface shared_op_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] req_opa;
  logic [16*NUM_REQ-1:0] req_opb;
  logic [NUM_REQ-1:0]    req_done;
  logic [31:0]           result;
  logic                  result_overflow;
  logic [NUM_REQ-1:0]    grant;
  logic                  busy;
  logic [31:0]           unit_outa;
  logic [15:0]           unit_outb;
  logic                  unit_start;
  logic                  unit_done;
  logic [31:0]           unit_in;
  logic                  unit_overflow;
  logic                  timeout_err;

  modport slave (
    input  req, req_opa, req_opb, unit_done, unit_in, unit_overflow,
    output req_done, result, result_overflow, grant, busy,
           unit_outa, unit_outb, unit_start, timeout_err
  );

  modport master (
    output req, req_opa, req_opb, unit_done, unit_in, unit_overflow,
    input  req_done, result, result_overflow, grant, busy,
           unit_outa, unit_outb, unit_start, timeout_err
  );
endinterface

// File: rtl/shared_op_arbiter.sv
// Round-robin arbiter sharing one multi-cycle start/done basic-op unit among NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining SHARED_OP_ARB_TIMEOUT_EN.
module shared_op_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clock,
  input  logic               reset,
  shared_op_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("shared_op_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [31:0]        opa_q, opa_d;
  logic [15:0]        opb_q, opb_d;
  logic [31:0]        result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               pend_q, pend_d;

  logic [31:0] opa_arr [NUM_REQ];
  logic [15:0] opb_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign opa_arr[gi] = bus.req_opa[32*gi +: 32];
      assign opb_arr[gi] = bus.req_opb[16*gi +: 16];
    end
  endgenerate

  // First requester at or after the pointer, wrapping modulo NUM_REQ.
  logic             sel_valid;
  logic [PTR_W-1:0] sel_idx;
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int               idx;
      logic [PTR_W-1:0] cand;
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = PTR_W'(idx);
      if (!sel_valid && bus.req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

`ifdef SHARED_OP_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    pend_d   = pend_q;
`ifdef SHARED_OP_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          gidx_d           = sel_idx;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          opa_d            = opa_arr[sel_idx];
          opb_d            = opb_arr[sel_idx];
          pend_d           = 1'b0;
          state_d          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A unit answering combinationally to its start is held until WAIT consumes it.
        if (bus.unit_done) begin
          result_d = bus.unit_in;
          ovf_d    = bus.unit_overflow;
          pend_d   = 1'b1;
        end
`ifdef SHARED_OP_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pend_q) begin
          state_d = S_RESP;
        end else if (bus.unit_done) begin
          result_d = bus.unit_in;
          ovf_d    = bus.unit_overflow;
          state_d  = S_RESP;
        end
`ifdef SHARED_OP_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          result_d = '0;
          ovf_d    = 1'b0;
          tmo_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESP: begin
        ptr_d   = (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + PTR_W'(1);
        grant_d = '0;
        pend_d  = 1'b0;
`ifdef SHARED_OP_ARB_TIMEOUT_EN
        tmo_d   = 1'b0;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
`ifdef SHARED_OP_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
`ifdef SHARED_OP_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign bus.busy            = (state_q != S_IDLE);
  assign bus.unit_start      = (state_q == S_ISSUE);
  assign bus.unit_outa       = opa_q;
  assign bus.unit_outb       = opb_q;
  assign bus.grant           = grant_q;
  assign bus.req_done        = (state_q == S_RESP) ? grant_q : '0;
  assign bus.result          = result_q;
  assign bus.result_overflow = ovf_q;
`ifdef SHARED_OP_ARB_TIMEOUT_EN
  assign bus.timeout_err     = (state_q == S_RESP) && tmo_q;
`else
  assign bus.timeout_err     = 1'b0;
`endif
endmodule
